sound_dac_multi: RTL and testbench
==================================

SOUND_DAC_MULTI -- requirements
Module: sound_dac_multi

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent 1-bit DAC channels (1..8).
REQ-002 Parameter BIT_WIDTH, default 16: signed sample width per channel (4..24).
REQ-003 Parameter ORDER, default 1: modulator order, 1 or 2; other values rejected at elaboration.
REQ-004 Parameter DIV, default 5: CLK cycles per modulator update (1..255); 108 MHz/5 = 21.6 MHz.
REQ-005 Parameter GAIN_BITS, default 8: mute-ramp gain resolution; full gain = 2^GAIN_BITS.
REQ-006 Parameter RAMP_STEP, default 64: modulator updates per gain step (1..65535).
REQ-007 CLK  input  1  system clock (108 MHz); all logic on rising edge; one clock only.
REQ-008 RESET_n  input  1  asynchronous, active-low reset.
REQ-009 IN_DATA  input  CHANNELS*BIT_WIDTH  signed two's-complement samples; channel n at bits [n*BIT_WIDTH +: BIT_WIDTH].
REQ-010 SAMPLE_STB  input  1  single-cycle strobe; latches IN_DATA for all channels.
REQ-011 MUTE  input  1  level; 1 requests ramp to silence, 0 requests ramp to full gain.
REQ-012 OUT  output  CHANNELS  registered 1-bit modulator outputs.
REQ-013 MUTED  output  1  registered; 1 exactly when ramp state is MUTED_S.

Function
REQ-014 Divider counts DIV-1 down to 0 then reloads; internal CLK_EN is 1 on cycles where count==0; with DIV=1 it is 1 every cycle.
REQ-015 SAMPLE_STB latches IN_DATA into hold registers on the same edge; the modulator uses hold registers only, so STB coincident with CLK_EN applies the new sample at the next CLK_EN.
REQ-016 Scaled sample = (hold * gain) arithmetic-shifted right GAIN_BITS, product width BIT_WIDTH+GAIN_BITS+1, result truncated to BIT_WIDTH signed; gain 0..2^GAIN_BITS inclusive.
REQ-017 ORDER=1: x = scaled with MSB inverted (offset binary); acc is BIT_WIDTH+1 bits; on CLK_EN acc <= {0, acc[BIT_WIDTH-1:0]} + x; OUT[n] <= acc carry bit (bit BIT_WIDTH) of the new value.
REQ-018 ORDER=2: signed integrators i1, i2, width BIT_WIDTH+4; fb = +2^(BIT_WIDTH-1) if OUT[n]=1, else -2^(BIT_WIDTH-1); on CLK_EN i1 <= i1 + scaled - fb, i2 <= i2 + i1_new - fb, OUT[n] <= (i2_new >= 0); both integrators saturate at their signed limits, never wrap.
REQ-019 OUT and modulator state change only on CLK_EN cycles.
REQ-020 Ramp FSM states: MUTED_S (gain 0), RAMP_UP, ACTIVE (gain 2^GAIN_BITS), RAMP_DOWN.
REQ-021 MUTED_S -> RAMP_UP when MUTE=0; ACTIVE -> RAMP_DOWN when MUTE=1.
REQ-022 Step counter counts CLK_EN pulses; every RAMP_STEP-th CLK_EN in RAMP_UP gain += 1, in RAMP_DOWN gain -= 1.
REQ-023 RAMP_UP -> ACTIVE on the step reaching 2^GAIN_BITS; RAMP_DOWN -> MUTED_S on the step reaching 0.
REQ-024 MUTE=1 during RAMP_UP -> RAMP_DOWN from current gain; MUTE=0 during RAMP_DOWN -> RAMP_UP from current gain; step counter clears on every state change.
REQ-025 All channels share one gain value and one FSM.

Reset
REQ-026 RESET_n=0 asynchronously forces: divider = DIV-1, hold = 0, acc/i1/i2 = 0, OUT = 0, gain = 0, step counter = 0, state MUTED_S, MUTED = 1.
REQ-027 Reset asserted mid-ramp or mid-sample aborts immediately; after release the block behaves as from power-up.

Structure
REQ-028 Shared package sound_dac_pkg holds the ramp-state enum and the ORDER legality check constant.
REQ-029 One sub-module, sound_dac_mod, implements a single channel's modulator (ORDER-selectable) and is instantiated CHANNELS times; divider, hold latching, gain multiply and FSM remain in the top.

Verification
REQ-030 ORDER=1, BIT_WIDTH=4, DIV=1, gain forced full, sample 0 -> OUT[0] alternates 0,1,0,1 starting 0.
REQ-031 ORDER=1, BIT_WIDTH=4, DIV=1, full gain, sample +7 -> exactly 15 ones in any 16 consecutive CLK_EN; sample -8 -> 0 ones in 16.
REQ-032 DIV=5: OUT transitions only on every 5th CLK edge after reset release; STB coincident with CLK_EN -> new sample effective 5 cycles later.
REQ-033 GAIN_BITS=8, RAMP_STEP=1, DIV=1, MUTE 1->0 -> ACTIVE after exactly 256 CLK_EN; MUTED deasserts 1 cycle after MUTE falls.
REQ-034 MUTE toggled 1 at gain 100 in RAMP_UP -> gain decreases 99,98,...; MUTED_S after 100 further steps.
REQ-035 ORDER=2, BIT_WIDTH=8, sample +127 held 10000 updates -> integrators saturate, no wrap, ones density >= 0.99; reset pulse mid-run -> OUT=0, MUTED=1 immediately.

Source files
------------

// File: rtl/sound_dac_pkg.sv
// rtl/sound_dac_pkg.sv - shared ramp-state type and modulator-order legality helpers
package sound_dac_pkg;

  // Mute-ramp controller states shared by every channel
  typedef enum logic [1:0] {
    MUTED_S   = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_e;

  // Supported modulator orders
  localparam int ORDER_MIN = 1;
  localparam int ORDER_MAX = 2;

  function automatic bit order_is_legal(input int order);
    return (order >= ORDER_MIN) && (order <= ORDER_MAX);
  endfunction

endpackage

// File: rtl/sound_dac_mod.sv
// rtl/sound_dac_mod.sv - single-channel 1-bit delta-sigma modulator, first or second order
module sound_dac_mod
  import sound_dac_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int ORDER     = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clk_en_i,
  input  logic signed [BIT_WIDTH-1:0] sample_i,
  output logic                        out_o
);

  if (ORDER == ORDER_MIN) begin : g_order1
    // Offset-binary input: flipping the sign bit maps -2^(W-1)..2^(W-1)-1 onto 0..2^W-1
    logic [BIT_WIDTH-1:0] x;
    logic [BIT_WIDTH:0]   acc_q;
    logic [BIT_WIDTH:0]   acc_d;

    assign x     = {~sample_i[BIT_WIDTH-1], sample_i[BIT_WIDTH-2:0]};
    assign acc_d = {1'b0, acc_q[BIT_WIDTH-1:0]} + {1'b0, x};
    // The carry of the stored accumulator is the output bit itself
    assign out_o = acc_q[BIT_WIDTH];

    // Accumulate once per modulator update
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        acc_q <= '0;
      end else if (clk_en_i) begin
        acc_q <= acc_d;
      end
    end
  end else begin : g_order2
    localparam int IW = BIT_WIDTH + 4;
    localparam int SW = BIT_WIDTH + 6;
    localparam logic signed [SW-1:0] I_MAX  = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] I_MIN  = {3'b111, {(IW-1){1'b0}}};
    localparam logic signed [SW-1:0] FB_POS = {{(SW-BIT_WIDTH){1'b0}}, 1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0] FB_NEG = {{(SW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    logic signed [IW-1:0] i1_q, i2_q, i1_d, i2_d;
    logic signed [SW-1:0] fb, i1_sum, i2_sum;
    logic                 out_q;

    // Clamp a wide sum into the integrator range instead of wrapping
    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
      if (v > I_MAX) begin
        return IW'(I_MAX);
      end else if (v < I_MIN) begin
        return IW'(I_MIN);
      end
      return IW'(v);
    endfunction

    assign fb     = out_q ? FB_POS : FB_NEG;
    assign i1_sum = {{(SW-IW){i1_q[IW-1]}}, i1_q}
                  + {{(SW-BIT_WIDTH){sample_i[BIT_WIDTH-1]}}, sample_i} - fb;
    assign i1_d   = sat(i1_sum);
    assign i2_sum = {{(SW-IW){i2_q[IW-1]}}, i2_q} + {{(SW-IW){i1_d[IW-1]}}, i1_d} - fb;
    assign i2_d   = sat(i2_sum);
    assign out_o  = out_q;

    // Two cascaded saturating integrators with a shared 1-bit feedback
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        i1_q  <= '0;
        i2_q  <= '0;
        out_q <= 1'b0;
      end else if (clk_en_i) begin
        i1_q  <= i1_d;
        i2_q  <= i2_d;
        out_q <= ~i2_d[IW-1];
      end
    end
  end

endmodule

// File: rtl/sound_dac_multi.sv
// rtl/sound_dac_multi.sv - multi-channel 1-bit audio DAC with shared mute ramp
module sound_dac_multi
  import sound_dac_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int BIT_WIDTH = 16,
  parameter int ORDER     = 1,
  parameter int DIV       = 5,
  parameter int GAIN_BITS = 8,
  parameter int RAMP_STEP = 64
) (
  input  logic                          CLK,
  input  logic                          RESET_n,
  input  logic [CHANNELS*BIT_WIDTH-1:0] IN_DATA,
  input  logic                          SAMPLE_STB,
  input  logic                          MUTE,
  output logic [CHANNELS-1:0]           OUT,
  output logic                          MUTED
);

  if (!order_is_legal(ORDER)) begin : g_order_check
    $error("sound_dac_multi: ORDER must be 1 or 2");
  end

  localparam int              GW        = GAIN_BITS + 1;
  localparam int              PW        = BIT_WIDTH + GAIN_BITS + 1;
  localparam logic [7:0]      DIV_LOAD  = 8'(DIV - 1);
  localparam logic [15:0]     STEP_LAST = 16'(RAMP_STEP - 1);
  localparam logic [GW-1:0]   GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GW-1:0]   GAIN_NEAR = GAIN_FULL - {{GAIN_BITS{1'b0}}, 1'b1};
  localparam logic [GW-1:0]   GAIN_ONE  = {{GAIN_BITS{1'b0}}, 1'b1};

  logic [7:0]                    div_q;
  logic [7:0]                    div_d;
  logic                          clk_en;
  logic [CHANNELS*BIT_WIDTH-1:0] hold_q;
  logic [GW-1:0]                 gain_q;
  logic [15:0]                   step_q;
  ramp_state_e                   state_q;
  logic                          muted_q;
  logic [CHANNELS-1:0]           out_w;

  assign clk_en = (div_q == 8'd0);
  assign div_d  = clk_en ? DIV_LOAD : div_q - 8'd1;

  // Update-rate divider: enable pulses when the down-counter hits zero
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      div_q <= DIV_LOAD;
    end else begin
      div_q <= div_d;
    end
  end

  // Sample hold; the modulators only ever read these registers
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      hold_q <= '0;
    end else if (SAMPLE_STB) begin
      hold_q <= IN_DATA;
    end
  end

  // Mute ramp: MUTE is honoured on any cycle, gain steps only on update cycles
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= MUTED_S;
      gain_q  <= '0;
      step_q  <= '0;
      muted_q <= 1'b1;
    end else begin
      case (state_q)
        MUTED_S: begin
          if (!MUTE) begin
            state_q <= RAMP_UP;
            step_q  <= '0;
            muted_q <= 1'b0;
          end
        end
        RAMP_UP: begin
          if (MUTE) begin
            step_q <= '0;
            // Nothing to ramp down from: fall straight back to silence
            if (gain_q == '0) begin
              state_q <= MUTED_S;
              muted_q <= 1'b1;
            end else begin
              state_q <= RAMP_DOWN;
            end
          end else if (clk_en) begin
            if (step_q == STEP_LAST) begin
              step_q <= '0;
              gain_q <= gain_q + GAIN_ONE;
              if (gain_q == GAIN_NEAR) begin
                state_q <= ACTIVE;
              end
            end else begin
              step_q <= step_q + 16'd1;
            end
          end
        end
        ACTIVE: begin
          if (MUTE) begin
            state_q <= RAMP_DOWN;
            step_q  <= '0;
          end
        end
        RAMP_DOWN: begin
          if (!MUTE) begin
            step_q  <= '0;
            // Already at full gain: no ramp needed
            state_q <= (gain_q == GAIN_FULL) ? ACTIVE : RAMP_UP;
          end else if (clk_en) begin
            if (step_q == STEP_LAST) begin
              step_q <= '0;
              gain_q <= gain_q - GAIN_ONE;
              if (gain_q == GAIN_ONE) begin
                state_q <= MUTED_S;
                muted_q <= 1'b1;
              end
            end else begin
              step_q <= step_q + 16'd1;
            end
          end
        end
        default: begin
          state_q <= MUTED_S;
          muted_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic signed [PW-1:0]        hold_ext;
    logic signed [PW-1:0]        gain_ext;
    logic signed [BIT_WIDTH-1:0] scaled;

    assign hold_ext = {{(GAIN_BITS+1){hold_q[n*BIT_WIDTH+BIT_WIDTH-1]}},
                       hold_q[n*BIT_WIDTH +: BIT_WIDTH]};
    assign gain_ext = {{BIT_WIDTH{1'b0}}, gain_q};
    assign scaled   = BIT_WIDTH'((hold_ext * gain_ext) >>> GAIN_BITS);

    sound_dac_mod #(
      .BIT_WIDTH (BIT_WIDTH),
      .ORDER     (ORDER)
    ) u_mod (
      .clk_i    (CLK),
      .rst_ni   (RESET_n),
      .clk_en_i (clk_en),
      .sample_i (scaled),
      .out_o    (out_w[n])
    );
  end

  assign OUT   = out_w;
  assign MUTED = muted_q;

endmodule

// File: tb/tb_sound_dac_multi.sv
// tb/tb_sound_dac_multi.sv - scoreboard bench for two sound_dac_multi configurations
module tb_sound_dac_multi;

  localparam int CH   = 2;
  localparam int A_BW = 4, A_DIV = 1, A_GB = 8, A_RS = 1, A_ORD = 1;
  localparam int B_BW = 8, B_DIV = 5, B_GB = 4, B_RS = 2, B_ORD = 2;
  localparam int M_MUTED = 0, M_UP = 1, M_ACTIVE = 2, M_DOWN = 3;

  typedef struct {
    logic [CH-1:0] out;
    logic          muted;
    int            gain;
  } exp_t;

  logic               CLK = 1'b0;
  logic               RESET_n = 1'b0;
  logic               MUTE = 1'b1;
  logic [CH*A_BW-1:0] a_data = '0;
  logic [CH*B_BW-1:0] b_data = '0;
  logic               a_stb = 1'b0;
  logic               b_stb = 1'b0;
  logic [CH-1:0]      a_out, b_out;
  logic               a_muted, b_muted;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state, index 0 = config A, 1 = config B
  int m_div[2], m_mode[2], m_gain[2], m_step[2];
  int m_hold[2][CH], m_acc[2][CH], m_i1[2][CH], m_i2[2][CH];
  bit m_out[2][CH];

  always #5 CLK = ~CLK;

  sound_dac_multi #(.CHANNELS(CH), .BIT_WIDTH(A_BW), .ORDER(A_ORD), .DIV(A_DIV),
                    .GAIN_BITS(A_GB), .RAMP_STEP(A_RS)) u_a (
    .CLK(CLK), .RESET_n(RESET_n), .IN_DATA(a_data), .SAMPLE_STB(a_stb),
    .MUTE(MUTE), .OUT(a_out), .MUTED(a_muted));

  sound_dac_multi #(.CHANNELS(CH), .BIT_WIDTH(B_BW), .ORDER(B_ORD), .DIV(B_DIV),
                    .GAIN_BITS(B_GB), .RAMP_STEP(B_RS)) u_b (
    .CLK(CLK), .RESET_n(RESET_n), .IN_DATA(b_data), .SAMPLE_STB(b_stb),
    .MUTE(MUTE), .OUT(b_out), .MUTED(b_muted));

  function automatic void check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int p_bw(input int k);  return (k == 0) ? A_BW  : B_BW;  endfunction
  function automatic int p_div(input int k); return (k == 0) ? A_DIV : B_DIV; endfunction
  function automatic int p_gb(input int k);  return (k == 0) ? A_GB  : B_GB;  endfunction
  function automatic int p_rs(input int k);  return (k == 0) ? A_RS  : B_RS;  endfunction
  function automatic int p_ord(input int k); return (k == 0) ? A_ORD : B_ORD; endfunction

  function automatic int chan_val(input logic [31:0] d, input int n, input int bw);
    int v;
    v = int'((d >> (n * bw)) & ((32'd1 << bw) - 32'd1));
    if (v >= (1 << (bw - 1))) v -= (1 << bw);
    return v;
  endfunction

  function automatic int clamp(input int v, input int lim);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // One clock edge of the behavioural model; returns the outputs expected after it
  function automatic exp_t model_step(input int k, input bit rst, input bit mute,
                                      input bit stb, input logic [31:0] data);
    exp_t e;
    int bw, full, half, lim, scaled, sum, fb;
    bit en;
    bw   = p_bw(k);
    full = 1 << p_gb(k);
    half = 1 << (bw - 1);
    lim  = 1 << (bw + 3);
    if (rst) begin
      m_div[k] = p_div(k) - 1;
      m_mode[k] = M_MUTED;
      m_gain[k] = 0;
      m_step[k] = 0;
      for (int n = 0; n < CH; n++) begin
        m_hold[k][n] = 0; m_acc[k][n] = 0; m_i1[k][n] = 0; m_i2[k][n] = 0; m_out[k][n] = 0;
      end
    end else begin
      en = (m_div[k] == 0);
      m_div[k] = en ? p_div(k) - 1 : m_div[k] - 1;
      if (en) begin
        for (int n = 0; n < CH; n++) begin
          scaled = (m_hold[k][n] * m_gain[k]) >>> p_gb(k);
          if (p_ord(k) == 1) begin
            sum = (m_acc[k][n] % (2 * half)) + scaled + half;
            m_out[k][n] = (sum >= 2 * half);
            m_acc[k][n] = sum;
          end else begin
            fb = m_out[k][n] ? half : -half;
            m_i1[k][n] = clamp(m_i1[k][n] + scaled - fb, lim);
            m_i2[k][n] = clamp(m_i2[k][n] + m_i1[k][n] - fb, lim);
            m_out[k][n] = (m_i2[k][n] >= 0);
          end
        end
      end
      case (m_mode[k])
        M_MUTED: if (!mute) begin m_mode[k] = M_UP; m_step[k] = 0; end
        M_UP: begin
          if (mute) begin
            m_mode[k] = (m_gain[k] == 0) ? M_MUTED : M_DOWN;
            m_step[k] = 0;
          end else if (en) begin
            m_step[k]++;
            if (m_step[k] == p_rs(k)) begin
              m_step[k] = 0;
              m_gain[k]++;
              if (m_gain[k] == full) m_mode[k] = M_ACTIVE;
            end
          end
        end
        M_ACTIVE: if (mute) begin m_mode[k] = M_DOWN; m_step[k] = 0; end
        default: begin
          if (!mute) begin
            m_mode[k] = (m_gain[k] == full) ? M_ACTIVE : M_UP;
            m_step[k] = 0;
          end else if (en) begin
            m_step[k]++;
            if (m_step[k] == p_rs(k)) begin
              m_step[k] = 0;
              m_gain[k]--;
              if (m_gain[k] == 0) m_mode[k] = M_MUTED;
            end
          end
        end
      endcase
      if (stb) begin
        for (int n = 0; n < CH; n++) m_hold[k][n] = chan_val(data, n, bw);
      end
    end
    for (int n = 0; n < CH; n++) e.out[n] = m_out[k][n];
    e.muted = (m_mode[k] == M_MUTED);
    e.gain  = m_gain[k];
    return e;
  endfunction

  // Stimulus side: the model turns every edge's inputs into a queued expectation
  always @(posedge CLK) begin
    q_a.push_back(model_step(0, !RESET_n, MUTE, a_stb, 32'(a_data)));
    q_b.push_back(model_step(1, !RESET_n, MUTE, b_stb, 32'(b_data)));
  end

  // Monitor: compare DUT outputs against queued expectations away from the active edge
  always @(negedge CLK) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_out", a_out, e.out);
      check("a_muted", a_muted, e.muted);
      check("a_gain", u_a.gain_q, e.gain);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_out", b_out, e.out);
      check("b_muted", b_muted, e.muted);
      check("b_gain", u_b.gain_q, e.gain);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic pulse_a(input logic [CH*A_BW-1:0] d);
    a_data = d; a_stb = 1'b1; step(1); a_stb = 1'b0;
  endtask

  task automatic wait_active(input string nm);
    int c = 0;
    while (!(u_a.gain_q == 9'd256 && u_b.gain_q == 5'd16) && c < 1000) begin step(1); c++; end
    check(nm, (c < 1000), 1);
  endtask

  task automatic wait_muted(input string nm);
    int c = 0;
    while (!(a_muted && b_muted) && c < 1000) begin step(1); c++; end
    check(nm, (c < 1000), 1);
  endtask

  task automatic reset_pulse(input string nm);
    RESET_n = 1'b0;
    #1;
    check({nm, "_a_out"}, a_out, 0);
    check({nm, "_b_out"}, b_out, 0);
    check({nm, "_a_muted"}, a_muted, 1);
    check({nm, "_b_muted"}, b_muted, 1);
    step(2);
    RESET_n = 1'b1;
    step(3);
  endtask

  initial begin
    int  cnt;
    int  ones;
    logic prev;

    step(3);
    check("rst_a_out", a_out, 0);
    check("rst_b_out", b_out, 0);
    check("rst_a_muted", a_muted, 1);
    check("rst_b_muted", b_muted, 1);
    RESET_n = 1'b1;
    step(5);

    // Ramp up from silence; MUTED falls one edge after MUTE, full gain 256 edges later
    MUTE = 1'b0;
    #1;
    check("muted_before_edge", a_muted, 1);
    step(1);
    check("muted_after_edge", a_muted, 0);
    cnt = 1;
    while (u_a.gain_q != 9'd256 && cnt < 400) begin step(1); cnt++; end
    check("ramp_up_edges", cnt, 257);
    wait_active("active_timeout_1");

    // Zero input at full gain: output toggles every update
    pulse_a('0);
    step(3);
    prev = a_out[0];
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("alt_zero", a_out[0], !prev);
      prev = a_out[0];
    end

    // Positive and negative full scale densities over 16 updates
    pulse_a({4'h7, 4'h7});
    step(3);
    ones = 0;
    for (int i = 0; i < 16; i++) begin step(1); ones += int'(a_out[0]); end
    check("ones_plus7", ones, 15);
    pulse_a({4'h8, 4'h8});
    step(3);
    ones = 0;
    for (int i = 0; i < 16; i++) begin step(1); ones += int'(a_out[1]); end
    check("ones_minus8", ones, 0);

    // Strobe coincident with an update enable on the divided config
    cnt = 0;
    while (m_div[1] != 0 && cnt < 10) begin step(1); cnt++; end
    b_data = 16'h9C40; b_stb = 1'b1; step(1); b_stb = 1'b0;
    step(12);

    // Reverse a ramp at gain 100: back to silence after 100 more steps
    MUTE = 1'b1;
    wait_muted("muted_timeout_1");
    MUTE = 1'b0;
    cnt = 0;
    while (m_gain[0] != 100 && cnt < 400) begin step(1); cnt++; end
    check("reach_gain_100", (cnt < 400), 1);
    MUTE = 1'b1;
    cnt = 0;
    while (!a_muted && cnt < 400) begin step(1); cnt++; end
    check("ramp_down_edges", cnt, 101);

    // Randomized traffic with occasional mute changes and a mid-run reset
    MUTE = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      a_data = CH*A_BW'($urandom);
      b_data = CH*B_BW'($urandom);
      a_stb  = ($urandom_range(3) == 0);
      b_stb  = ($urandom_range(3) == 0);
      if ($urandom_range(299) == 0) MUTE = ~MUTE;
      if ($urandom_range(999) == 0) MUTE = ~MUTE;
      if (i == 1500) begin
        a_stb = 1'b0;
        b_stb = 1'b0;
        reset_pulse("rst_rand");
      end
      step(1);
    end
    a_stb = 1'b0;
    b_stb = 1'b0;

    // Second-order config held at +127 for 10000 updates
    MUTE = 1'b0;
    wait_active("active_timeout_2");
    b_data = 16'h7F7F; b_stb = 1'b1; step(1); b_stb = 1'b0;
    step(10);
    ones = 0;
    for (int i = 0; i < 10000; i++) begin step(5); ones += int'(b_out[0]); end
    check("density_ge_9900", (ones >= 9900), 1);
    reset_pulse("rst_density");
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
